// File: rtl/rv32_mvu_job_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_mvu_job_arbiter_pkg
//  Description : Shared types and constants for the MVU job arbiter. Holds
//                the arbiter state encoding, the default timeout and the
//                hart index width used on the CSR-bundle select.
//  Contents    : NUM_HARTS_DEFAULT, HART_CNT_WIDTH, MVU_ARB_TIMEOUT,
//                MVU_ARB_TO_W, mvu_arb_state_e
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_mvu_job_arbiter_pkg;

    // Number of barrel harts sharing the MVU and the width of a hart index.
    localparam int NUM_HARTS_DEFAULT = 8;
    localparam int HART_CNT_WIDTH    = $clog2(NUM_HARTS_DEFAULT);

    // Default BUSY-cycle budget before a job is aborted (0 = never abort),
    // and the width of the counter that measures it.
    localparam int MVU_ARB_TIMEOUT   = 4096;
    localparam int MVU_ARB_TO_W      = 16;

    // Arbiter state machine encoding.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LAUNCH = 2'd2,
        ARB_BUSY   = 2'd3
    } mvu_arb_state_e;

endpackage : rv32_mvu_job_arbiter_pkg
`default_nettype wire

// File: rtl/rv32_mvu_job_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_mvu_job_arbiter_rr_pick
//  Description : Combinational round-robin picker. Searches req starting at
//                last+1 (mod NUM_HARTS) and returns the first set index.
//                Implemented as rotate / priority-encode / un-rotate.
//  Ports       : req       in  NUM_HARTS       request vector
//                last      in  HART_CNT_WIDTH  previously granted index
//                gnt_idx   out HART_CNT_WIDTH  chosen index (valid if gnt_valid)
//                gnt_valid out 1               any request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_mvu_job_arbiter_rr_pick
    import rv32_mvu_job_arbiter_pkg::*;
#(
    parameter int NUM_HARTS = NUM_HARTS_DEFAULT
)(
    input  logic [NUM_HARTS-1:0]      req,
    input  logic [HART_CNT_WIDTH-1:0] last,
    output logic [HART_CNT_WIDTH-1:0] gnt_idx,
    output logic                      gnt_valid
);

    localparam logic [HART_CNT_WIDTH-1:0] LAST_IDX    = HART_CNT_WIDTH'(NUM_HARTS - 1);
    localparam logic [HART_CNT_WIDTH:0]   NUM_HARTS_W = (HART_CNT_WIDTH + 1)'(NUM_HARTS);

    logic [HART_CNT_WIDTH:0]   w_start;     // search origin, one extra bit for the select
    logic [2*NUM_HARTS-1:0]    w_dbl;       // req concatenated with itself for wrap-free rotate
    logic [NUM_HARTS-1:0]      w_rot;       // req rotated so w_start sits at bit 0
    logic [HART_CNT_WIDTH-1:0] w_pos;       // lowest set bit of the rotated vector
    logic                      w_found;
    logic [HART_CNT_WIDTH:0]   w_sum_raw;   // un-rotated index before the modulo
    logic [HART_CNT_WIDTH:0]   w_sum;

    always_comb begin
        // Origin is last+1, wrapping NUM_HARTS-1 back to 0 (also guards an
        // out-of-range last when NUM_HARTS is not a power of two).
        if (last >= LAST_IDX) begin
            w_start = '0;
        end else begin
            w_start = {1'b0, last} + 1'b1;
        end

        w_dbl = {req, req};
        w_rot = w_dbl[w_start +: NUM_HARTS];

        w_pos   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (w_rot[i] && !w_found) begin
                w_pos   = HART_CNT_WIDTH'(i);
                w_found = 1'b1;
            end
        end

        w_sum_raw = w_start + {1'b0, w_pos};
        if (w_sum_raw >= NUM_HARTS_W) begin
            w_sum = w_sum_raw - NUM_HARTS_W;
        end else begin
            w_sum = w_sum_raw;
        end

        gnt_idx   = w_sum[HART_CNT_WIDTH-1:0];
        gnt_valid = |req;
    end

endmodule : rv32_mvu_job_arbiter_rr_pick
`default_nettype wire

// File: rtl/rv32_mvu_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_mvu_job_arbiter
//  Description : Shares one MVU datapath among NUM_HARTS barrel harts.
//                Queues per-hart start pulses, grants round-robin, drives
//                the CSR-bundle select, launches the MVU and waits for done
//                or timeout, then returns a per-hart irq / timeout pulse.
//  Ports       : clk          in  1               clock
//                rst_n        in  1               async reset, active low
//                mvu_start_i  in  NUM_HARTS       per-hart start pulse
//                mvu_done_i   in  1               MVU job complete pulse
//                mvu_go_o     out 1               launch pulse to MVU
//                mvu_abort_o  out 1               abort pulse on timeout
//                mvu_sel_o    out HART_CNT_WIDTH  hart routed to the MVU
//                mvu_busy_o   out 1               high in GRANT/LAUNCH/BUSY
//                mvu_irq_o    out NUM_HARTS       per-hart completion pulse
//                timeout_o    out NUM_HARTS       per-hart timeout pulse
//                pending_o    out NUM_HARTS       queued requests
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_mvu_job_arbiter
    import rv32_mvu_job_arbiter_pkg::*;
#(
    parameter int NUM_HARTS      = NUM_HARTS_DEFAULT,
    parameter int TIMEOUT_CYCLES = MVU_ARB_TIMEOUT,
    parameter int TO_W           = MVU_ARB_TO_W
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_HARTS-1:0]      mvu_start_i,
    input  logic                      mvu_done_i,
    output logic                      mvu_go_o,
    output logic                      mvu_abort_o,
    output logic [HART_CNT_WIDTH-1:0] mvu_sel_o,
    output logic                      mvu_busy_o,
    output logic [NUM_HARTS-1:0]      mvu_irq_o,
    output logic [NUM_HARTS-1:0]      timeout_o,
    output logic [NUM_HARTS-1:0]      pending_o
);

    // Terminal count of the BUSY counter; only meaningful when the timeout
    // is enabled.
    localparam bit                        TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0]           TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HART_CNT_WIDTH-1:0] LAST_RST = HART_CNT_WIDTH'(NUM_HARTS - 1);

    mvu_arb_state_e            r_state;
    logic [NUM_HARTS-1:0]      r_pending;
    logic [HART_CNT_WIDTH-1:0] r_last;
    logic [HART_CNT_WIDTH-1:0] r_sel;
    logic [TO_W-1:0]           r_to_cnt;
    logic                      r_go;
    logic                      r_abort;
    logic                      r_busy;
    logic [NUM_HARTS-1:0]      r_irq;
    logic [NUM_HARTS-1:0]      r_timeout;

    logic [HART_CNT_WIDTH-1:0] w_gnt_idx;
    logic                      w_gnt_valid;
    logic                      w_grant;
    logic [NUM_HARTS-1:0]      w_clr;
    logic [NUM_HARTS-1:0]      w_sel_onehot;
    logic                      w_timeout_hit;

    // ------------------------------------------------------------------------
    // Round-robin selection over the registered request queue
    // ------------------------------------------------------------------------
    rv32_mvu_job_arbiter_rr_pick #(
        .NUM_HARTS (NUM_HARTS)
    ) u_rr_pick (
        .req       (r_pending),
        .last      (r_last),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    assign w_grant       = (r_state == ARB_IDLE) && w_gnt_valid;
    assign w_timeout_hit = TO_EN && (r_to_cnt == TO_LAST);

    always_comb begin
        w_clr = '0;
        if (w_grant) begin
            w_clr[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_onehot        = '0;
        w_sel_onehot[r_sel] = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Request queue: a set in the same cycle as the grant-clear wins, so a
    // start arriving exactly as the hart is granted becomes a new job.
    // Repeated starts for a pending hart collapse into the single bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | mvu_start_i;
        end
    end

    // ------------------------------------------------------------------------
    // Arbiter FSM with registered pulse outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_last    <= LAST_RST;
            r_sel     <= '0;
            r_to_cnt  <= '0;
            r_go      <= 1'b0;
            r_abort   <= 1'b0;
            r_busy    <= 1'b0;
            r_irq     <= '0;
            r_timeout <= '0;
        end else begin
            // Pulse outputs default low; each is raised for one cycle only.
            r_go      <= 1'b0;
            r_abort   <= 1'b0;
            r_irq     <= '0;
            r_timeout <= '0;

            case (r_state)
                ARB_IDLE: begin
                    if (w_gnt_valid) begin
                        r_sel   <= w_gnt_idx;
                        r_last  <= w_gnt_idx;
                        r_busy  <= 1'b1;
                        r_state <= ARB_GRANT;
                    end
                end

                // One settle cycle so the selected CSR bundle is stable at
                // the MVU before go is raised.
                ARB_GRANT: begin
                    r_go    <= 1'b1;
                    r_state <= ARB_LAUNCH;
                end

                // go is high during this cycle; a done here is not for the
                // job just launched and is ignored.
                ARB_LAUNCH: begin
                    r_to_cnt <= '0;
                    r_state  <= ARB_BUSY;
                end

                // Done takes priority over a coincident timeout.
                ARB_BUSY: begin
                    if (mvu_done_i) begin
                        r_irq   <= w_sel_onehot;
                        r_busy  <= 1'b0;
                        r_state <= ARB_IDLE;
                    end else if (w_timeout_hit) begin
                        r_abort   <= 1'b1;
                        r_timeout <= w_sel_onehot;
                        r_busy    <= 1'b0;
                        r_state   <= ARB_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mvu_go_o    = r_go;
    assign mvu_abort_o = r_abort;
    assign mvu_sel_o   = r_sel;
    assign mvu_busy_o  = r_busy;
    assign mvu_irq_o   = r_irq;
    assign timeout_o   = r_timeout;
    assign pending_o   = r_pending;

endmodule : rv32_mvu_job_arbiter
`default_nettype wire

// File: tb/tb_rv32_mvu_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_mvu_job_arbiter
//  Description : Directed self-checking bench for rv32_mvu_job_arbiter with
//                NUM_HARTS=8 and TIMEOUT_CYCLES=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_mvu_job_arbiter;

    localparam int NH = 8;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic [NH-1:0] start;
    logic          done;
    logic          go;
    logic          abort;
    logic [2:0]    sel;
    logic          busy;
    logic [NH-1:0] irq;
    logic [NH-1:0] tmo;
    logic [NH-1:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    rv32_mvu_job_arbiter #(
        .NUM_HARTS      (NH),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mvu_start_i (start),
        .mvu_done_i  (done),
        .mvu_go_o    (go),
        .mvu_abort_o (abort),
        .mvu_sel_o   (sel),
        .mvu_busy_o  (busy),
        .mvu_irq_o   (irq),
        .timeout_o   (tmo),
        .pending_o   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_go"},      32'(go),      32'h0);
        chk({tag, "_abort"},   32'(abort),   32'h0);
        chk({tag, "_sel"},     32'(sel),     32'h0);
        chk({tag, "_busy"},    32'(busy),    32'h0);
        chk({tag, "_irq"},     32'(irq),     32'h0);
        chk({tag, "_tmo"},     32'(tmo),     32'h0);
        chk({tag, "_pending"}, 32'(pending), 32'h0);
    endtask

    // Called in an IDLE cycle in which hart h is the next round-robin pick.
    // Done is driven d cycles after the go cycle; 'mid' is pulsed mcnt times
    // (every other cycle) during BUSY; ldone drives a stray done in LAUNCH.
    task automatic expect_job(input int h, input int d, input logic [NH-1:0] mid,
                              input int mcnt, input bit ldone);
        logic [NH-1:0] oh;
        oh = NH'(1) << h;
        tick();
        chk("grant_sel",      32'(sel),        32'(h));
        chk("grant_busy",     32'(busy),       32'h1);
        chk("grant_pend_clr", 32'(pending[h]), 32'h0);
        chk("grant_no_go",    32'(go),         32'h0);
        tick();
        chk("launch_go",      32'(go),         32'h1);
        chk("launch_busy",    32'(busy),       32'h1);
        done = ldone;
        for (int i = 1; i <= d; i++) begin
            tick();
            done  = (i == d);
            start = ((i % 2 == 1) && (i < 2 * mcnt)) ? mid : '0;
            chk("run_busy",   32'(busy), 32'h1);
            chk("run_no_irq", 32'(irq),  32'h0);
            chk("run_no_go",  32'(go),   32'h0);
        end
        tick();
        done  = 1'b0;
        start = '0;
        chk("done_irq",      32'(irq),   32'(oh));
        chk("done_busy",     32'(busy),  32'h0);
        chk("done_no_abort", 32'(abort), 32'h0);
        chk("done_no_tmo",   32'(tmo),   32'h0);
    endtask

    // Called in an IDLE cycle in which hart h is the next pick; done never comes.
    task automatic expect_timeout(input int h);
        logic [NH-1:0] oh;
        oh = NH'(1) << h;
        tick();
        chk("to_grant_sel", 32'(sel), 32'(h));
        tick();
        chk("to_go", 32'(go), 32'h1);
        for (int i = 1; i <= TO; i++) begin
            tick();
            chk("to_wait_abort", 32'(abort), 32'h0);
            chk("to_wait_busy",  32'(busy),  32'h1);
        end
        tick();
        chk("to_abort",  32'(abort), 32'h1);
        chk("to_tmo",    32'(tmo),   32'(oh));
        chk("to_no_irq", 32'(irq),   32'h0);
        chk("to_idle",   32'(busy),  32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Pulse-width and exclusivity monitors.
    logic          prev_go    = 1'b0;
    logic          prev_abort = 1'b0;
    logic [NH-1:0] prev_irq   = '0;

    always @(negedge clk) begin
        if (go)     chk("mon_go_pulse",    32'(prev_go),    32'h0);
        if (abort)  chk("mon_abort_pulse", 32'(prev_abort), 32'h0);
        if (irq != '0) chk("mon_irq_pulse", 32'(prev_irq),  32'h0);
        if ((irq | tmo) != '0) chk("mon_onehot0", 32'($onehot(irq | tmo)), 32'h1);
        prev_go    <= go;
        prev_abort <= abort;
        prev_irq   <= irq;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = '0;
        done  = 1'b0;
        tick();
        tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_rst");

        // 1: single job on hart 2, done 10 cycles after go
        start = 8'h04;
        tick();
        start = '0;
        chk("t1_pending", 32'(pending), 32'h04);
        chk("t1_idle",    32'(busy),    32'h0);
        expect_job(2, 10, '0, 0, 1'b0);

        // 2: contention from a fresh reset: 0,3,7 then {0,7} -> 0,7
        do_reset();
        start = 8'h89;
        tick();
        start = '0;
        chk("t2_pending", 32'(pending), 32'h89);
        expect_job(0, 5, '0, 0, 1'b0);
        chk("t2_pend_after0", 32'(pending), 32'h88);
        expect_job(3, 5, '0, 0, 1'b0);
        expect_job(7, 5, '0, 0, 1'b0);
        start = 8'h81;
        tick();
        start = '0;
        expect_job(0, 5, '0, 0, 1'b0);
        expect_job(7, 5, '0, 0, 1'b0);

        // 3: timeout on hart 5, hart 6 waiting behind it
        start = 8'h60;
        tick();
        start = '0;
        expect_timeout(5);
        chk("t3_next_pending", 32'(pending), 32'h40);
        expect_job(6, 3, '0, 0, 1'b0);

        // 4: start[1] x3 while pending -> one job; done coinciding with the
        //    timeout; start[1] during its own BUSY; stray done in LAUNCH
        start = 8'h04;
        tick();
        start = '0;
        expect_job(2, 8, 8'h02, 3, 1'b0);
        chk("t4_absorbed", 32'(pending), 32'h02);
        expect_job(1, TO, 8'h02, 1, 1'b0);
        chk("t4_requeued", 32'(pending), 32'h02);
        expect_job(1, 4, '0, 0, 1'b1);
        chk("t4_drained", 32'(pending), 32'h00);

        // 6: stray done in IDLE
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t6_idle_no_irq",  32'(irq),  32'h0);
        chk("t6_idle_no_busy", 32'(busy), 32'h0);
        tick();
        chk("t6_idle_no_irq2", 32'(irq),  32'h0);

        // 5: reset mid-BUSY with pending = A5
        start = 8'h02;
        tick();
        start = '0;
        tick();
        chk("t5_sel", 32'(sel), 32'h1);
        tick();
        tick();
        start = 8'hA5;
        tick();
        start = '0;
        chk("t5_pending", 32'(pending), 32'hA5);
        chk("t5_busy",    32'(busy),    32'h1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_in_rst");
        tick();
        tick();
        rst_n = 1'b1;
        chk_all_zero("t5_released");
        tick();
        chk_all_zero("t5_after");
        start = 8'hFF;
        tick();
        start = '0;
        expect_job(0, 2, '0, 0, 1'b0);
        chk("t5_pend_fe", 32'(pending), 32'hFE);
        expect_job(1, 2, '0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rv32_mvu_job_arbiter
`default_nettype wire
